// File: rtl/vga_scan_out.sv
// VGA raster timing, framebuffer address generation and RGB332 -> 8:8:8 expansion.
// Optional VGA_TEST_PATTERN_EN adds a test_pattern input that replaces pixels with colour bars.

module vga_scan_out #(
  parameter int unsigned H_ACTIVE    = 640,
  parameter int unsigned H_FP        = 16,
  parameter int unsigned H_SYNC      = 96,
  parameter int unsigned H_BP        = 48,
  parameter int unsigned V_ACTIVE    = 480,
  parameter int unsigned V_FP        = 10,
  parameter int unsigned V_SYNC      = 2,
  parameter int unsigned V_BP        = 33,
  parameter int unsigned SCALE_SHIFT = 1,
  parameter int unsigned RD_LAT      = 1
) (
  input  logic        clk_vga,
  input  logic        reset,
`ifdef VGA_TEST_PATTERN_EN
  input  logic        test_pattern,
`endif
  output logic [31:0] vga_pixel_addr,
  input  logic [7:0]  vga_pixel_val,
  output logic        vga_hsync,
  output logic        vga_vsync,
  output logic        vga_blank_n,
  output logic        vga_sync_n,
  output logic [7:0]  vga_r,
  output logic [7:0]  vga_g,
  output logic [7:0]  vga_b,
  output logic        frame_start
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned H_W     = $clog2(H_TOTAL);
  localparam int unsigned V_W     = $clog2(V_TOTAL);
  localparam int unsigned FB_W    = H_ACTIVE >> SCALE_SHIFT;
`ifdef VGA_TEST_PATTERN_EN
  localparam int unsigned PIPE_W  = 8;
`else
  localparam int unsigned PIPE_W  = 4;
`endif
  // Idle pipeline word: inactive, both syncs deasserted (high), no frame marker.
  localparam logic [PIPE_W-1:0] PIPE_IDLE = PIPE_W'(4'b0110) << (PIPE_W - 4);

  localparam logic [H_W-1:0] H_LAST = H_W'(H_TOTAL - 1);
  localparam logic [H_W-1:0] H_ACT  = H_W'(H_ACTIVE);
  localparam logic [H_W-1:0] HS_BEG = H_W'(H_ACTIVE + H_FP);
  localparam logic [H_W-1:0] HS_END = H_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [V_W-1:0] V_LAST = V_W'(V_TOTAL - 1);
  localparam logic [V_W-1:0] V_ACT  = V_W'(V_ACTIVE);
  localparam logic [V_W-1:0] VS_BEG = V_W'(V_ACTIVE + V_FP);
  localparam logic [V_W-1:0] VS_END = V_W'(V_ACTIVE + V_FP + V_SYNC);

  logic [H_W-1:0]           h_cnt;
  logic [V_W-1:0]           v_cnt;
  logic                     active_c;
  logic                     hsync_raw_c;
  logic                     vsync_raw_c;
  logic                     frame_c;
  logic [PIPE_W-1:0]        pipe_d_c;
  logic [RD_LAT*PIPE_W-1:0] pipe_q;
  logic [PIPE_W-1:0]        tail_c;
  logic [7:0]               pix_c;

  // Raster counters; the vertical counter only moves on a horizontal wrap.
  always_ff @(posedge clk_vga) begin
    if (!reset) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + V_W'(1);
    end else begin
      h_cnt <= h_cnt + H_W'(1);
    end
  end

  always_comb begin
    active_c       = (h_cnt < H_ACT) && (v_cnt < V_ACT);
    hsync_raw_c    = !((h_cnt >= HS_BEG) && (h_cnt < HS_END));
    vsync_raw_c    = !((v_cnt >= VS_BEG) && (v_cnt < VS_END));
    frame_c        = (h_cnt == '0) && (v_cnt == '0);
    vga_pixel_addr = '0;
    if (active_c) begin
      vga_pixel_addr = 32'(v_cnt >> SCALE_SHIFT) * 32'(FB_W) + 32'(h_cnt >> SCALE_SHIFT);
    end
`ifdef VGA_TEST_PATTERN_EN
    pipe_d_c = {active_c, hsync_raw_c, vsync_raw_c, frame_c, test_pattern, 3'(h_cnt >> 7)};
`else
    pipe_d_c = {active_c, hsync_raw_c, vsync_raw_c, frame_c};
`endif
  end

  // Delay line matching the pixel memory read latency.
  if (RD_LAT == 1) begin : g_lat_one
    always_ff @(posedge clk_vga) begin
      if (!reset) pipe_q <= PIPE_IDLE;
      else        pipe_q <= pipe_d_c;
    end
  end else begin : g_lat_multi
    always_ff @(posedge clk_vga) begin
      if (!reset) pipe_q <= {RD_LAT{PIPE_IDLE}};
      else        pipe_q <= {pipe_q[(RD_LAT-1)*PIPE_W-1:0], pipe_d_c};
    end
  end

  always_comb begin
    tail_c = pipe_q[RD_LAT*PIPE_W-1 -: PIPE_W];
    pix_c  = vga_pixel_val;
`ifdef VGA_TEST_PATTERN_EN
    if (tail_c[3]) begin
      pix_c = {{3{tail_c[2]}}, {3{tail_c[1]}}, {2{tail_c[0]}}};
    end
`endif
  end

  assign vga_sync_n = 1'b0;

  // Output register: aligns timing flags with the returned pixel and expands the colour.
  always_ff @(posedge clk_vga) begin
    if (!reset) begin
      vga_hsync   <= 1'b1;
      vga_vsync   <= 1'b1;
      vga_blank_n <= 1'b0;
      frame_start <= 1'b0;
      vga_r       <= '0;
      vga_g       <= '0;
      vga_b       <= '0;
    end else begin
      vga_blank_n <= tail_c[PIPE_W-1];
      vga_hsync   <= tail_c[PIPE_W-2];
      vga_vsync   <= tail_c[PIPE_W-3];
      frame_start <= tail_c[PIPE_W-4];
      if (tail_c[PIPE_W-1]) begin
        vga_r <= {pix_c[7:5], pix_c[7:5], pix_c[7:6]};
        vga_g <= {pix_c[4:2], pix_c[4:2], pix_c[4:3]};
        vga_b <= {4{pix_c[1:0]}};
      end else begin
        vga_r <= '0;
        vga_g <= '0;
        vga_b <= '0;
      end
    end
  end

endmodule
